kmc_obus_npr: RTL

- KMC11 output-side datapath. It is the destination counterpart of the DMUX source selector.
- Decodes the microword destination field and writes ALU results into the BRG, OBUS registers (NPR data/address) and OBUSS registers (CSR bytes, NPRC, MISC).
- Sequences the NPR (DMA) transfer that the microcode requests through NPRC.
- Sits between the KMC ALU and the Unibus DMA interface. Its register outputs feed the DMUX.

---
 rtl/kmc_obus_pkg.sv | 46 ++++
 rtl/kmc_npr_seq.sv | 74 +++++++
 rtl/kmc_obus_npr.sv | 131 +++++++++++++
 3 files changed

// File: rtl/kmc_obus_pkg.sv
// KMC11 output-side datapath definitions: microword field extract, destination
// and register address encodings, NPRC/MISC bit positions and NPR FSM states.
package kmc_obus_pkg;

  // DST = CRAM[12:11]; code 0 means no destination
  localparam logic [1:0] DST_BRG   = 2'd1;
  localparam logic [1:0] DST_OBUS  = 2'd2;
  localparam logic [1:0] DST_OBUSS = 2'd3;

  localparam logic [3:0] OB_NPROD_L = 4'd0;
  localparam logic [3:0] OB_NPROD_H = 4'd1;
  localparam logic [3:0] OB_NPRIA_L = 4'd2;
  localparam logic [3:0] OB_NPRIA_H = 4'd3;
  localparam logic [3:0] OB_NPROA_L = 4'd4;
  localparam logic [3:0] OB_NPROA_H = 4'd5;

  localparam logic [3:0] OBS_NPRC = 4'd8;
  localparam logic [3:0] OBS_MISC = 4'd9;

  localparam int NPRC_BYTE = 1;
  localparam int NPRC_XA   = 2;
  localparam int NPRC_OUT  = 4;
  localparam int MISC_NXM  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } npr_st_e;

  typedef struct packed {
    logic        wr;
    logic        bt;
    logic [17:0] addr;
    logic [15:0] dato;
  } npr_req_t;

  function automatic logic [1:0] cram_dst(input logic [15:0] cram);
    return cram[12:11];
  endfunction

  function automatic logic [3:0] cram_adr(input logic [15:0] cram);
    return cram[3:0];
  endfunction

endpackage

// File: rtl/kmc_npr_seq.sv
// NPR transfer sequencer: IDLE/REQ/DONE FSM, per-transfer address/data latch and
// the optional acknowledge timeout (KMC_NPR_TIMEOUT_EN).
module kmc_npr_seq
  import kmc_obus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:1]  ctl,
  input  logic [15:0] nprod,
  input  logic [15:0] npria,
  input  logic [15:0] nproa,
  input  logic        ack,
  output logic        busy,
  output logic        req,
  output npr_req_t    cur,
  output logic        nprid_we,
  output logic        tmo
);

  npr_st_e st;

  assign req      = (st == ST_REQ);
  assign nprid_we = req && ack && !cur.wr;

`ifdef KMC_NPR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // cnt holds the number of REQ cycles already elapsed
  assign tmo = req && !ack && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || !req) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end
`else
  logic unused_to;
  assign unused_to = (TIMEOUT == 0);
  assign tmo       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st   <= ST_IDLE;
      busy <= 1'b0;
      cur  <= '0;
    end else begin
      case (st)
        // busy already set here means a start was accepted during DONE
        ST_IDLE: if (start || busy) begin
          st       <= ST_REQ;
          busy     <= 1'b1;
          cur.wr   <= ctl[NPRC_OUT];
          cur.bt   <= ctl[NPRC_BYTE];
          cur.addr <= {ctl[NPRC_XA+1:NPRC_XA], ctl[NPRC_OUT] ? nproa : npria};
          cur.dato <= nprod;
        end
        ST_REQ: if (ack || tmo) begin
          st   <= ST_DONE;
          busy <= 1'b0;
        end
        ST_DONE: begin
          st <= ST_IDLE;
          if (start) busy <= 1'b1;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kmc_obus_npr.sv
// KMC11 destination datapath: decodes the microword DST field into BRG/OBUS/OBUSS
// register writes and drives NPR transfers. Option: KMC_NPR_TIMEOUT_EN.
module kmc_obus_npr
  import kmc_obus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] kmcCRAM,
  input  logic [7:0]  kmcALU,
  input  logic        kmcSTEP,
  input  logic [7:0]  kmcHOSTWR,
  input  logic [15:0] kmcHOSTD,
  input  logic        kmcNPRACK,
  input  logic [15:0] kmcNPRDATI,
  output logic        kmcNPRREQ,
  output logic        kmcNPRWR,
  output logic        kmcNPRBYTE,
  output logic [17:0] kmcNPRADDR,
  output logic [15:0] kmcNPRDATO,
  output logic [15:0] kmcNPRID,
  output logic [15:0] kmcNPROD,
  output logic [15:0] kmcNPRIA,
  output logic [15:0] kmcNPROA,
  output logic [15:0] kmcCSR0,
  output logic [15:0] kmcCSR2,
  output logic [15:0] kmcCSR4,
  output logic [15:0] kmcCSR6,
  output logic [7:0]  kmcNPRC,
  output logic [7:0]  kmcMISC,
  output logic [7:0]  kmcBRG
);

  logic [1:0]      dst;
  logic [3:0]      adr;
  logic            wr_brg, wr_ob, wr_obs, nprc_we, misc_we, start;
  logic [7:0]      brg, misc;
  logic [7:1]      nprc_hi;
  logic [4:1]      nprc_ctl;
  logic [15:0]     nprod, npria, nproa, nprid;
  logic [7:0][7:0] csr_q;
  logic            busy, req, nprid_we, tmo;
  npr_req_t        cur;
  logic            unused_cram;

  assign dst         = cram_dst(kmcCRAM);
  assign adr         = cram_adr(kmcCRAM);
  assign unused_cram = ^{kmcCRAM[15:13], kmcCRAM[10:4]};

  assign wr_brg  = kmcSTEP && (dst == DST_BRG);
  assign wr_ob   = kmcSTEP && (dst == DST_OBUS);
  assign wr_obs  = kmcSTEP && (dst == DST_OBUSS);
  assign nprc_we = wr_obs && (adr == OBS_NPRC);
  assign misc_we = wr_obs && (adr == OBS_MISC);
  assign start   = nprc_we && kmcALU[0];

  // control bits as they will stand after this edge, so a start write latches its own mode
  assign nprc_ctl = nprc_we ? kmcALU[4:1] : nprc_hi[4:1];

  kmc_npr_seq #(.TIMEOUT(TIMEOUT)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ctl      (nprc_ctl),
    .nprod    (nprod),
    .npria    (npria),
    .nproa    (nproa),
    .ack      (kmcNPRACK),
    .busy     (busy),
    .req      (req),
    .cur      (cur),
    .nprid_we (nprid_we),
    .tmo      (tmo)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      brg     <= '0;
      misc    <= '0;
      nprc_hi <= '0;
      nprod   <= '0;
      npria   <= '0;
      nproa   <= '0;
      nprid   <= '0;
      csr_q   <= '0;
    end else begin
      if (wr_brg) brg <= kmcALU;
      if (wr_ob) begin
        case (adr)
          OB_NPROD_L: nprod[7:0]  <= kmcALU;
          OB_NPROD_H: nprod[15:8] <= kmcALU;
          OB_NPRIA_L: npria[7:0]  <= kmcALU;
          OB_NPRIA_H: npria[15:8] <= kmcALU;
          OB_NPROA_L: nproa[7:0]  <= kmcALU;
          OB_NPROA_H: nproa[15:8] <= kmcALU;
          default: ;
        endcase
      end
      if (nprc_we)  nprc_hi <= kmcALU[7:1];
      if (misc_we)  misc    <= kmcALU;
      if (tmo)      misc[MISC_NXM] <= 1'b1;
      if (nprid_we) nprid   <= kmcNPRDATI;
      // host strobe owns its byte outright; micro write only lands when the host is silent
      for (int i = 0; i < 8; i++) begin
        if (kmcHOSTWR[i])
          csr_q[i] <= (i % 2 == 1) ? kmcHOSTD[15:8] : kmcHOSTD[7:0];
        else if (wr_obs && (adr == 4'(i)))
          csr_q[i] <= kmcALU;
      end
    end
  end

  assign kmcNPRREQ  = req;
  assign kmcNPRWR   = cur.wr;
  assign kmcNPRBYTE = cur.bt;
  assign kmcNPRADDR = cur.addr;
  assign kmcNPRDATO = cur.dato;
  assign kmcNPRID   = nprid;
  assign kmcNPROD   = nprod;
  assign kmcNPRIA   = npria;
  assign kmcNPROA   = nproa;
  assign kmcCSR0    = {csr_q[1], csr_q[0]};
  assign kmcCSR2    = {csr_q[3], csr_q[2]};
  assign kmcCSR4    = {csr_q[5], csr_q[4]};
  assign kmcCSR6    = {csr_q[7], csr_q[6]};
  assign kmcNPRC    = {nprc_hi, busy};
  assign kmcMISC    = misc;
  assign kmcBRG     = brg;

endmodule
